// File: rtl/key_debounce_if.sv
// Push-button signal bundle: raw key toward the debouncer, clean level and
// press/release strobes back toward the counter stage.
interface key_debounce_if;
  logic KEY;
  logic KEY_OUT;
  logic PULSE;
  logic REL_PULSE;

  modport master (
    output KEY,
    input  KEY_OUT,
    input  PULSE,
    input  REL_PULSE
  );

  modport slave (
    input  KEY,
    output KEY_OUT,
    output PULSE,
    output REL_PULSE
  );
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser, then a 4-state debounce FSM
// that produces a clean level plus one-cycle press and release strobes.
module key_debounce #(
  parameter int DB_CYCLES = 20,
  parameter int CNT_W     = 5
) (
  input  logic           CLK,
  input  logic           RST,
  key_debounce_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s1_d;
  logic             ks_q, ks_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_out_q, key_out_d;
  logic             pulse_q, pulse_d;
  logic             rel_pulse_q, rel_pulse_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q        <= 1'b0;
      ks_q        <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_out_q   <= 1'b0;
      pulse_q     <= 1'b0;
      rel_pulse_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      ks_q        <= ks_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_out_q   <= key_out_d;
      pulse_q     <= pulse_d;
      rel_pulse_q <= rel_pulse_d;
    end
  end

  // A bounce (ks disagreeing with the pending level) is tested before the
  // terminal count, so a glitch on the final cycle still cancels the change.
  always_comb begin
    s1_d        = bus.KEY;
    ks_d        = s1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_out_d   = key_out_q;
    pulse_d     = 1'b0;
    rel_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        key_out_d = 1'b0;
        if (ks_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end

      PRESS_WAIT: begin
        key_out_d = 1'b0;
        if (!ks_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = PRESSED;
          cnt_d     = '0;
          key_out_d = 1'b1;
          pulse_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        key_out_d = 1'b1;
        if (!ks_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end

      RELEASE_WAIT: begin
        key_out_d = 1'b1;
        if (ks_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          key_out_d   = 1'b0;
          rel_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        key_out_d = 1'b0;
      end
    endcase
  end

  assign bus.KEY_OUT   = key_out_q;
  assign bus.PULSE     = pulse_q;
  assign bus.REL_PULSE = rel_pulse_q;

  strobes_exclusive: assert property (@(posedge CLK) disable iff (RST)
    !(pulse_q && rel_pulse_q));

endmodule
